decode_hazard_ctrl: RTL and testbench

Pipeline controller that sequences the decode stage of the 16-bit, 16-register processor. It tracks outstanding register writes in a scoreboard, stalls decode on RAW/WAW hazards, and squashes younger instructions on a taken branch. It drives the PC and IR enables, issue into execute, and bubble insertion; it also keeps a stall-cycle performance counter.

---
 rtl/decode_ctrl_pkg.sv | 16 +
 rtl/hazard_scoreboard.sv | 66 ++++++
 rtl/decode_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the decode-stage pipeline controller.
package decode_ctrl_pkg;

  localparam int unsigned NREGS_DEF  = 16;
  localparam int unsigned REG_AW_DEF = 4;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // Decode sequencing states.
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } dec_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues and cleared by its writeback; provides busy lookups for the
// decode-stage source and destination fields.
module hazard_scoreboard
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned NREGS     = NREGS_DEF,
  parameter int unsigned REG_AW    = REG_AW_DEF,
  parameter int unsigned WB_BYPASS = 0,
  parameter int unsigned R0_ZERO   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rd_pending,
  output logic [NREGS-1:0]  pending
);

  logic [NREGS-1:0] pending_nxt;

  function automatic logic is_r0(input logic [REG_AW-1:0] r);
    return (R0_ZERO != 0) && (r == '0);
  endfunction

  // A writeback landing this cycle can satisfy a reader when bypass is enabled.
  function automatic logic wb_hits(input logic wb_en, input logic [REG_AW-1:0] wb_idx,
                                   input logic [REG_AW-1:0] r);
    return (WB_BYPASS != 0) && wb_en && (wb_idx == r);
  endfunction

  // Source busy lookups (bypass-aware) and destination pending lookup (not bypassed).
  always_comb begin
    rs1_busy   = pending[rs1] & ~wb_hits(clr_en, clr_idx, rs1) & ~is_r0(rs1);
    rs2_busy   = pending[rs2] & ~wb_hits(clr_en, clr_idx, rs2) & ~is_r0(rs2);
    rd_pending = pending[rd] & ~is_r0(rd);
  end

  // Clear applied first so a same-cycle new writer to the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) begin
      pending_nxt[clr_idx] = 1'b0;
    end
    if (set_en && !is_r0(set_idx)) begin
      pending_nxt[set_idx] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencer: stalls on RAW/WAW hazards against the pending-write
// scoreboard, squashes younger instructions after a taken branch, drives the
// fetch/issue enables and counts stall cycles.
module decode_hazard_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned NREGS        = NREGS_DEF,
  parameter int unsigned REG_AW       = REG_AW_DEF,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WB_BYPASS    = 0,
  parameter int unsigned R0_ZERO      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic              wr_rd,
  input  logic              ex_ready,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              br_taken,
  output logic              id_issue,
  output logic              pc_en,
  output logic              ir_en,
  output logic              id_bubble,
  output logic              if_flush,
  output logic [NREGS-1:0]  pending,
  output logic [15:0]       stall_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  dec_state_t state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic       rs1_busy, rs2_busy, rd_pending;
  logic       hazard, issue_ok, stall_inc;

  hazard_scoreboard #(
    .NREGS    (NREGS),
    .REG_AW   (REG_AW),
    .WB_BYPASS(WB_BYPASS),
    .R0_ZERO  (R0_ZERO)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (id_issue & wr_rd),
    .set_idx   (rd),
    .clr_en    (wb_valid),
    .clr_idx   (wb_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_pending(rd_pending),
    .pending   (pending)
  );

  // Hazard detection and the common issue condition.
  always_comb begin
    hazard   = id_valid & ((use_rs1 & rs1_busy) | (use_rs2 & rs2_busy) | (wr_rd & rd_pending));
    issue_ok = id_valid & ~hazard & ex_ready & ~br_taken;
  end

  // Next-state and combinational control outputs; a taken branch overrides all states.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    id_issue      = 1'b0;
    pc_en         = 1'b0;
    ir_en         = 1'b0;
    id_bubble     = 1'b0;
    if (!rst) begin
      state_nxt     = ST_RUN;
      flush_cnt_nxt = '0;
    end else if (br_taken) begin
      id_bubble     = 1'b1;
      pc_en         = 1'b1;
      ir_en         = 1'b1;
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      unique case (state)
        ST_RUN: begin
          id_issue = issue_ok;
          if (id_valid && (hazard || !ex_ready)) begin
            state_nxt = ST_STALL;
            id_bubble = hazard;
          end else begin
            pc_en = 1'b1;
            ir_en = 1'b1;
          end
        end
        ST_STALL: begin
          id_issue  = issue_ok;
          pc_en     = issue_ok;
          ir_en     = issue_ok;
          id_bubble = hazard;
          if (issue_ok) begin
            state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          id_bubble = 1'b1;
          pc_en     = 1'b1;
          ir_en     = 1'b1;
          if (flush_cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 3'd1;
          end
        end
        default: begin
          state_nxt     = ST_RUN;
          flush_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Fetch invalidate is a decode of the registered state.
  always_comb begin
    if_flush = rst & (state == ST_FLUSH);
  end

  // State and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // A cycle counts as stalled when held in STALL or when RUN fails to issue a valid instruction.
  always_comb begin
    stall_inc = (state == ST_STALL) |
                ((state == ST_RUN) & id_valid & ~id_issue & ~br_taken);
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != STALL_CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Bench for decode_hazard_ctrl: two instances (writeback bypass off / on)
// share stimulus; each is compared every cycle to a behavioural model built
// from the hazard, stall, flush and scoreboard rules, plus directed scenarios.
module tb_decode_hazard_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, use_rs1, use_rs2, wr_rd, ex_ready, wb_valid, br_taken;
  logic [3:0]  rs1, rs2, rd, wb_rd;
  logic        issue_o [2];
  logic        pc_o    [2];
  logic        ir_o    [2];
  logic        bub_o   [2];
  logic        iff_o   [2];
  logic [15:0] pend_o  [2];
  logic [15:0] stall_o [2];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per instance.
  bit [15:0] m_pend  [2];
  int        m_flush [2];   // remaining squash cycles, 0 when not squashing
  bit        m_held  [2];   // an instruction is being held back in decode
  int        m_cnt   [2];

  always #5 clk = ~clk;

  decode_hazard_ctrl #(
    .NREGS(16), .REG_AW(4), .FLUSH_CYCLES(FC), .WB_BYPASS(0), .R0_ZERO(1)
  ) u_dut_nobyp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .wr_rd(wr_rd), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_taken(br_taken),
    .id_issue(issue_o[0]), .pc_en(pc_o[0]), .ir_en(ir_o[0]), .id_bubble(bub_o[0]),
    .if_flush(iff_o[0]), .pending(pend_o[0]), .stall_cnt(stall_o[0])
  );

  decode_hazard_ctrl #(
    .NREGS(16), .REG_AW(4), .FLUSH_CYCLES(FC), .WB_BYPASS(1), .R0_ZERO(1)
  ) u_dut_byp (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1(rs1), .rs2(rs2), .rd(rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .wr_rd(wr_rd), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_taken(br_taken),
    .id_issue(issue_o[1]), .pc_en(pc_o[1]), .ir_en(ir_o[1]), .id_bubble(bub_o[1]),
    .if_flush(iff_o[1]), .pending(pend_o[1]), .stall_cnt(stall_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_busy(input int k, input logic [3:0] r);
    if (r == 4'd0) return 1'b0;
    if (k == 1 && wb_valid && wb_rd == r) return 1'b0;
    return m_pend[k][r];
  endfunction

  function automatic void model_eval(input int k, output bit ei, output bit ep,
                                     output bit eb, output bit ef, output bit ep_dc);
    bit haz;
    bit flushing;
    haz = id_valid && ((use_rs1 && m_busy(k, rs1)) || (use_rs2 && m_busy(k, rs2)) ||
                       (wr_rd && rd != 4'd0 && m_pend[k][rd]));
    flushing = (m_flush[k] > 0);
    ef = flushing;
    ep_dc = 1'b0;
    ei = 1'b0;
    ep = 1'b0;
    eb = 1'b0;
    if (br_taken) begin
      eb = 1'b1;
      ep_dc = 1'b1;
    end else if (flushing) begin
      eb = 1'b1;
      ep = 1'b1;
    end else begin
      ei = id_valid && !haz && ex_ready;
      if (m_held[k]) begin
        ep = ei;
        eb = haz;
      end else if (id_valid && (haz || !ex_ready)) begin
        eb = haz;
      end else begin
        ep = 1'b1;
      end
    end
  endfunction

  function automatic void model_update(input int k);
    bit ei, ep, eb, ef, dc;
    bit flushing;
    model_eval(k, ei, ep, eb, ef, dc);
    flushing = (m_flush[k] > 0);
    if (m_held[k] || (!flushing && id_valid && !ei && !br_taken))
      if (m_cnt[k] < 65535) m_cnt[k]++;
    if (wb_valid) m_pend[k][wb_rd] = 1'b0;
    if (ei && wr_rd && rd != 4'd0) m_pend[k][rd] = 1'b1;
    if (br_taken) begin
      m_flush[k] = FC;
      m_held[k]  = 1'b0;
    end else if (flushing) begin
      m_flush[k]--;
    end else if (m_held[k]) begin
      m_held[k] = !ei;
    end else begin
      m_held[k] = id_valid && !ei;
    end
  endfunction

  task automatic set_instr(input bit v, input logic [3:0] r1, input logic [3:0] r2,
                           input logic [3:0] d, input bit u1, input bit u2, input bit w);
    id_valid = v; rs1 = r1; rs2 = r2; rd = d; use_rs1 = u1; use_rs2 = u2; wr_rd = w;
  endtask

  task automatic set_env(input bit rdy, input bit wv, input logic [3:0] wr, input bit br);
    ex_ready = rdy; wb_valid = wv; wb_rd = wr; br_taken = br;
  endtask

  // One clock: compare everything at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit ei, ep, eb, ef, dc;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_eval(k, ei, ep, eb, ef, dc);
      check($sformatf("issue%0d", k), 32'(issue_o[k]), 32'(ei));
      check($sformatf("bubble%0d", k), 32'(bub_o[k]), 32'(eb));
      check($sformatf("if_flush%0d", k), 32'(iff_o[k]), 32'(ef));
      check($sformatf("pending%0d", k), 32'(pend_o[k]), 32'(m_pend[k]));
      check($sformatf("stall_cnt%0d", k), 32'(stall_o[k]), 32'(m_cnt[k]));
      if (!dc) begin
        check($sformatf("pc_en%0d", k), 32'(pc_o[k]), 32'(ep));
        check($sformatf("ir_en%0d", k), 32'(ir_o[k]), 32'(ep));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
  endtask

  // Asserts reset with a valid, hazard-free instruction present so output gating is visible.
  task automatic do_reset();
    set_instr(1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_issue%0d", k), 32'(issue_o[k]), 32'd0);
      check($sformatf("rst_pc_en%0d", k), 32'(pc_o[k]), 32'd0);
      check($sformatf("rst_ir_en%0d", k), 32'(ir_o[k]), 32'd0);
      check($sformatf("rst_bubble%0d", k), 32'(bub_o[k]), 32'd0);
      check($sformatf("rst_if_flush%0d", k), 32'(iff_o[k]), 32'd0);
      check($sformatf("rst_pending%0d", k), 32'(pend_o[k]), 32'd0);
      check($sformatf("rst_stall_cnt%0d", k), 32'(stall_o[k]), 32'd0);
      m_pend[k] = '0; m_flush[k] = 0; m_held[k] = 1'b0; m_cnt[k] = 0;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    do_reset();

    // Build up some scoreboard state and a stall count, then reset mid-squash.
    set_instr(1'b1, 4'd0, 4'd0, 4'd4, 1'b0, 1'b0, 1'b1); tick();
    set_instr(1'b1, 4'd4, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b1); tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("pre_rst_if_flush", 32'(iff_o[0]), 32'd1);
    do_reset();

    // RAW on r3 without bypass: three stalled cycles, writeback, issue on the next.
    set_instr(1'b1, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 1'b1); tick();
    set_instr(1'b1, 4'd3, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1);
    #1;
    check("raw_bubble", 32'(bub_o[0]), 32'd1);
    check("raw_pc_en", 32'(pc_o[0]), 32'd0);
    tick(); tick();
    set_env(1'b1, 1'b1, 4'd3, 1'b0); tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    check("raw_issue", 32'(issue_o[0]), 32'd1);
    tick();
    check("raw_stall_cnt", 32'(stall_o[0]), 32'd4);
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    do_reset();

    // WAW on r5 with bypass: same-cycle writeback clears the RAW but not the WAW.
    set_instr(1'b1, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1); tick();
    set_instr(1'b1, 4'd5, 4'd0, 4'd5, 1'b1, 1'b0, 1'b1);
    set_env(1'b1, 1'b1, 4'd5, 1'b0);
    #1;
    check("waw_stall_issue", 32'(issue_o[1]), 32'd0);
    check("waw_stall_bubble", 32'(bub_o[1]), 32'd1);
    tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    check("waw_issue", 32'(issue_o[1]), 32'd1);
    tick();
    check("waw_pending5", 32'(pend_o[1][5]), 32'd1);
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); tick();
    do_reset();

    // Taken branch while stalled: instruction dropped, two squash cycles.
    set_instr(1'b1, 4'd0, 4'd0, 4'd6, 1'b0, 1'b0, 1'b1); tick();
    set_instr(1'b1, 4'd6, 4'd0, 4'd9, 1'b1, 1'b0, 1'b1); tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b1); tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    set_instr(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("br_if_flush_c%0d", i), 32'(iff_o[0]), (i < 2) ? 32'd1 : 32'd0);
      tick();
    end
    check("br_pending", 32'(pend_o[0]), 32'h0040);

    // Issue writing r7 alongside a writeback to r7: the new writer wins.
    do_reset();
    set_instr(1'b1, 4'd0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1);
    set_env(1'b1, 1'b1, 4'd7, 1'b0); tick();
    set_env(1'b1, 1'b0, 4'd0, 1'b0);
    check("sim_pending7", 32'(pend_o[0][7]), 32'd1);

    // r0 is never pending and never blocks a reader.
    set_instr(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); tick();
    set_instr(1'b1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0);
    #1;
    check("r0_issue", 32'(issue_o[0]), 32'd1);
    tick();
    check("r0_pending0", 32'(pend_o[0][0]), 32'd0);

    // Randomised traffic; a held instruction keeps its fields until it leaves decode.
    for (int n = 0; n < 3000; n++) begin
      if (!m_held[0] || $urandom_range(0, 19) == 0) begin
        set_instr($urandom_range(0, 99) < 75, 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 60);
      end
      set_env($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 40,
              4'($urandom_range(0, 7)), $urandom_range(0, 99) < 5);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
